// File: rtl/piccolo_sbox_pkg.sv
// Shared constants and types for the serial Piccolo S-box layer.
package piccolo_sbox_pkg;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] SBOX_FWD [16] = '{
    4'hE, 4'h4, 4'hB, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
    4'h1, 4'hA, 4'h7, 4'hF, 4'h6, 4'hC, 4'h5, 4'hD
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'h6, 4'h8, 4'h3, 4'h4, 4'h1, 4'hE, 4'hC, 4'hA,
    4'h5, 4'h7, 4'h9, 4'h2, 4'hD, 4'hF, 4'h0, 4'hB
  };

  // Counter width: never narrower than one bit so NCYC=1 still has a legal counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/piccolo_sbox4_lut.sv
// One Piccolo nibble substitution, forward or inverse, purely combinational.
module piccolo_sbox4_lut
  import piccolo_sbox_pkg::*;
(
  input  logic [3:0] a,
  input  logic       inv,
  output logic [3:0] q
);

  assign q = inv ? SBOX_INV[a] : SBOX_FWD[a];

endmodule

// File: rtl/piccolo_sbox_layer_serial.sv
// Piccolo S-box layer over a WIDTH-bit word, LANES nibbles per cycle, valid/ready on both sides.
module piccolo_sbox_layer_serial
  import piccolo_sbox_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_inv,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned NCYC = WIDTH / (4 * LANES);
  localparam int unsigned CntW = clog2(NCYC);
  localparam int unsigned LaneW = 4 * LANES;
  localparam logic [CntW-1:0] CntMax = CntW'(NCYC - 1);

  if ((LANES < 1) || (LANES > WIDTH / 4) || ((WIDTH % (4 * LANES)) != 0)) begin : gen_bad_params
    $error("piccolo_sbox_layer_serial: WIDTH must be a multiple of 4*LANES, LANES in 1..WIDTH/4");
  end

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic              inv_q, inv_d;
  logic [LaneW-1:0]  sub;
  logic [WIDTH-1:0]  shifted;

  for (genvar l = 0; l < LANES; l++) begin : gen_lane
    piccolo_sbox4_lut u_lut (
      .a   (shreg_q[4*l +: 4]),
      .inv (inv_q),
      .q   (sub[4*l +: 4])
    );
  end

  // Substituted nibbles enter at the top; after NCYC shifts the word is back in place.
  if (NCYC == 1) begin : gen_shift_full
    assign shifted = sub;
  end else begin : gen_shift_part
    assign shifted = {sub, shreg_q[WIDTH-1:LaneW]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shreg_d = in_data;
          inv_d   = in_inv;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        shreg_d = shifted;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntMax) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            shreg_d = in_data;
            inv_d   = in_inv;
            cnt_d   = '0;
            state_d = StBusy;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      inv_q   <= inv_d;
    end
  end

  assign out_data = shreg_q;

endmodule

// File: tb/tb_piccolo_sbox_layer_serial.sv
// Randomised self-checking bench: a 16-bit/1-lane instance plus 64-bit 16-lane and 4-lane instances.
module tb_piccolo_sbox_layer_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_inv;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  logic        w_in_valid  [2];
  logic        w_in_ready  [2];
  logic [63:0] w_in_data   [2];
  logic        w_in_inv    [2];
  logic        w_out_valid [2];
  logic        w_out_ready [2];
  logic [63:0] w_out_data  [2];

  int checks = 0;
  int errors = 0;

  int fwd_tab [16] = '{14, 4, 11, 2, 3, 8, 0, 9, 1, 10, 7, 15, 6, 12, 5, 13};

  piccolo_sbox_layer_serial #(.WIDTH(16), .LANES(1)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  piccolo_sbox_layer_serial #(.WIDTH(64), .LANES(16)) u_dut_l16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_in_valid[0]),
    .in_ready  (w_in_ready[0]),
    .in_data   (w_in_data[0]),
    .in_inv    (w_in_inv[0]),
    .out_valid (w_out_valid[0]),
    .out_ready (w_out_ready[0]),
    .out_data  (w_out_data[0])
  );

  piccolo_sbox_layer_serial #(.WIDTH(64), .LANES(4)) u_dut_l4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_in_valid[1]),
    .in_ready  (w_in_ready[1]),
    .in_data   (w_in_data[1]),
    .in_inv    (w_in_inv[1]),
    .out_valid (w_out_valid[1]),
    .out_ready (w_out_ready[1]),
    .out_data  (w_out_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: substitute each nibble from the forward table; inverse found by table search.
  function automatic logic [63:0] ref_sub(input logic [63:0] w, input int nib, input bit inv);
    logic [63:0] r;
    int v;
    r = '0;
    for (int i = 0; i < nib; i++) begin
      v = int'(w[4*i +: 4]);
      if (inv) begin
        for (int j = 0; j < 16; j++) if (fwd_tab[j] == v) r[4*i +: 4] = 4'(j);
      end else begin
        r[4*i +: 4] = 4'(fwd_tab[v]);
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for out_valid on the 16-bit DUT, checking in_ready stays low meanwhile.
  task automatic wait16(input string tag, input bit toggle);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
      if (toggle) in_inv = ~in_inv;
      in_valid = 1'($urandom);
      in_data  = 16'($urandom);
      step();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
  endtask

  task automatic run16(input string tag, input logic [15:0] d, input bit inv, input bit toggle,
                       output logic [15:0] res);
    check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    step();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    wait16(tag, toggle);
    check({tag, "_data"}, 64'(out_data), ref_sub(64'(d), 4, inv));
    res = out_data;
  endtask

  task automatic drain16();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic run_wide(input int k, input logic [63:0] d, input bit inv, input int ncyc);
    int lat;
    w_in_valid[k] = 1'b1;
    w_in_data[k]  = d;
    w_in_inv[k]   = inv;
    step();
    w_in_valid[k] = 1'b0;
    w_in_inv[k]   = ~inv;
    lat = 0;
    while (!w_out_valid[k] && lat < 80) begin
      step();
      lat++;
    end
    check((k == 0) ? "l16_latency" : "l4_latency", 64'(lat), 64'(ncyc));
    check((k == 0) ? "l16_data" : "l4_data", w_out_data[k], ref_sub(d, 16, inv));
    w_out_ready[k] = 1'b1;
    step();
    w_out_ready[k] = 1'b0;
  endtask

  initial begin
    logic [15:0] res, fw, held, w;
    logic [63:0] wd;
    bit          inv;

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w_in_valid[k] = 1'b0; w_in_data[k] = '0; w_in_inv[k] = 1'b0; w_out_ready[k] = 1'b0;
    end
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_l16_out_valid", 64'(w_out_valid[0]), 64'd0);
    check("rst_l4_out_data", w_out_data[1], 64'd0);
    #10 rst_n = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    run16("fwd0123", 16'h0123, 1'b0, 1'b0, res);
    check("fwd0123_const", 64'(res), 64'hE4B2);
    drain16();
    run16("invE4B2", 16'hE4B2, 1'b1, 1'b0, res);
    check("invE4B2_const", 64'(res), 64'h0123);
    drain16();

    // Round trip through the DUT with every nibble value in every position.
    for (int i = 0; i < 16; i++) begin
      w = {4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3)};
      run16("rt_fwd", w, 1'b0, 1'b0, fw);
      drain16();
      run16("rt_inv", fw, 1'b1, 1'b0, res);
      check("rt_identity", 64'(res), 64'(w));
      drain16();
    end

    for (int i = 0; i < 12; i++) begin
      inv = 1'($urandom);
      run16("rand16", 16'($urandom), inv, 1'b1, res);
      drain16();
    end

    run16("mode_latch", 16'h0000, 1'b1, 1'b1, res);
    check("mode_latch_const", 64'(res), 64'h6666);

    // Back-pressure on the held result, then accept a new word on the release edge.
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      step();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'(held));
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b1;
    in_data   = 16'h4567;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    #1;
    check("b2b_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    wait16("b2b", 1'b0);
    check("b2b_data", 64'(out_data), 64'h3809);
    drain16();

    // Reset two cycles into BUSY discards the word.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    in_inv   = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", 64'(out_data), 64'd0);
    #3 rst_n = 1'b1;
    step();
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_no_output", 64'(out_valid), 64'd0);
    run16("post_rst", 16'h89AB, 1'b0, 1'b0, res);
    check("post_rst_const", 64'(res), 64'h1A7F);
    drain16();

    run_wide(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
    run_wide(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4);
    for (int i = 0; i < 10; i++) begin
      wd  = {$urandom, $urandom};
      inv = 1'($urandom);
      run_wide(0, wd, inv, 1);
      run_wide(1, wd, inv, 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piccolo_sbox_layer_serial.md
Name: piccolo_sbox_layer_serial

Overview:
- Applies the Piccolo 4-bit S-box, or its inverse, to every nibble of a WIDTH-bit word.
- Processes LANES nibbles per clock, which trades area against latency.
- Replaces hand-instanced per-nibble S-box layers inside the F-function and datapath wrappers.
- Uses a valid/ready handshake on both sides so it can sit between round-register stages.

Parameters:
- WIDTH, 16: word width in bits. Must be a multiple of 4*LANES; any other value is an elaboration error.
- LANES, 1: nibbles substituted per cycle, range 1..WIDTH/4.
- NCYC (derived, not overridable) = WIDTH/(4*LANES): busy cycles per word.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  WIDTH  word to substitute
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled with in_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  substituted word, nibble i = S(in nibble i)

Behaviour:
- Single clock domain; reset is asynchronous and active-low.
- Reset state: out_valid=0, out_data=0, state=IDLE, counter=0, shift register=0, latched mode=0. in_ready is 1 as soon as rst_n deasserts.
- Forward table, nibble 0..F: E,4,B,2,3,8,0,9,1,A,7,F,6,C,5,D.
- Inverse table, nibble 0..F: 6,8,3,4,1,E,C,A,5,7,9,2,D,F,0,B.
- State IDLE:
  - in_ready=1.
  - On in_valid: load in_data into the shift register, latch in_inv, counter=0, go to BUSY.
- State BUSY:
  - in_ready=0 and out_valid=0.
  - Each cycle the low LANES nibbles pass through LANES parallel S-box instances.
  - The register shifts right by 4*LANES bits and the results are inserted at the top.
  - The counter increments each cycle.
  - When counter reaches NCYC-1, the final shift is written and the next state is DONE.
  - After NCYC shifts every nibble is back in its original position.
- State DONE:
  - out_valid=1. out_data equals the shift register and stays stable until accepted.
  - in_ready = out_ready.
  - out_valid & out_ready & in_valid: accept the new word in the same cycle and go to BUSY. This gives back-to-back throughput of one word per NCYC+1 cycles.
  - out_valid & out_ready & !in_valid: go to IDLE.
  - out_ready=0: hold. in_valid is ignored because in_ready=0.
- Latency: handshake at edge k produces out_valid=1 after edge k+NCYC.
  - NCYC=1 (LANES=WIDTH/4) gives one cycle of latency.
- in_inv is only sampled at acceptance. Changes while in BUSY or DONE have no effect.
- in_data is ignored except on the accept edge.
- Reset asserted mid-operation discards the word immediately; there is no output for it.
- out_data is registered; there is no combinational path from in_* to out_*.
- in_ready depends combinationally on out_ready in DONE only.

Decomposition:
- Package piccolo_sbox_pkg holds:
  - SBOX_FWD and SBOX_INV 16x4 constant tables;
  - the state enum (IDLE, BUSY, DONE);
  - a function clog2 for the counter width, which is max(1, clog2(NCYC)).
- Sub-module piccolo_sbox4_lut holds one nibble lookup with ports a[3:0], inv, q[3:0], purely combinational. It is instanced LANES times via generate.
- The forward path of the lookup may be built from the existing NOR/XOR gate primitives. The inverse path uses the table.

Test Plan:
- WIDTH=16, LANES=1, forward 0x0123 -> out_data=0xE4B2, out_valid rises after 4 edges, in_ready=0 during BUSY.
- WIDTH=16, LANES=1, inverse 0xE4B2 -> 0x0123. Also an exhaustive loop of all 16 nibbles, forward then inverse, must round-trip to the identity.
- WIDTH=64, LANES=16 (NCYC=1), forward 0xFFFF_FFFF_FFFF_FFFF -> 0xDDDD_DDDD_DDDD_DDDD after 1 cycle. Repeat with LANES=4 (NCYC=4) and check the same result.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_data/out_valid stable, in_ready=0, new in_valid not consumed. Then a simultaneous out_ready=1 and in_valid=1 with 0x4567 forward -> next result 0x3809, no bubble beyond the NCYC busy cycles.
- Reset mid-BUSY (rst_n low after 2 of 4 cycles) -> out_valid=0 and out_data=0 immediately. After release, in_ready=1 and a fresh word 0x89AB forward gives 0x1A7F.
- Mode latch: accept 0x0000 with in_inv=1, then toggle in_inv during BUSY -> result 0x6666.
